mem_arbiter: RTL
================

# mem_arbiter

Two-port round-robin arbiter that shares the single-ported `ram` block (firmware memory plus memory-mapped UART) between the core's instruction-fetch port and its load/store port. It sits between the core and `ram`. It drives `ram`'s read/write address, data and write-enable from the winning requester. It registers the read result and returns a one-cycle acknowledge to that requester. Arbitration is fair, with a bounded wait of one cycle.

## Interface
- `ADDRESS_WIDTH`, 12: byte address width; matches `ram`.
- `WIDTH`, 32: data word width; matches `ram`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDRESS_WIDTH  fetch byte address; stable while `if_req` is high.
- `if_ack`  out  1  one-cycle pulse: fetch access completed.
- `if_rdata`  out  WIDTH  fetched word; valid while `if_ack` is high, held until the next fetch ack.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read; stable while `d_req` is high.
- `d_addr`  in  ADDRESS_WIDTH  data byte address.
- `d_wdata`  in  WIDTH  write data.
- `d_ack`  out  1  one-cycle pulse: data access completed.
- `d_rdata`  out  WIDTH  read word; updated on read acks only.
- `mem_we`  out  1  to `ram.write_enable`.
- `mem_raddr`  out  ADDRESS_WIDTH  to `ram.read_addr`.
- `mem_waddr`  out  ADDRESS_WIDTH  to `ram.write_addr`.
- `mem_wdata`  out  WIDTH  to `ram.data_in`.
- `mem_rdata`  in  WIDTH  from `ram.data_out` (combinational read).

## Operation
- Eligibility:
  - `if_elig = if_req & ~if_ack`
  - `d_elig = d_req & ~d_ack`
  - A requester is never eligible in its own ack cycle. This prevents re-issuing a request the requester is just retiring.
- Grant is combinational each cycle:
  - Only one eligible requester: it wins.
  - Both eligible: the requester not recorded in `last_grant` wins.
  - Neither eligible: idle.
- Granted cycle, memory side:
  - `mem_raddr` = winner's address.
  - `mem_waddr = d_addr`.
  - `mem_wdata = d_wdata`.
  - `mem_we = d granted & d_we & ~rst`.
- Idle cycle, memory side:
  - `mem_we = 0`.
  - `mem_raddr = if_addr`, `mem_waddr = d_addr`, `mem_wdata = d_wdata` (don't-care values, but defined).
- On the edge ending a granted cycle:
  - Winner's ack register ← 1; the other requester's ack ← 0.
  - `last_grant` ← winner (0 = fetch, 1 = data).
  - Fetch win: `if_rdata ← mem_rdata`.
  - Data read win: `d_rdata ← mem_rdata`.
  - Data write win: `d_rdata` unchanged.
- Idle edge: both acks ← 0; `last_grant` unchanged.
- Address decode (RAM vs. UART) is entirely `ram`'s job; the arbiter passes addresses through untouched. This includes UART status polling through `d_addr`.
- Reset (`rst` high at an edge):
  - `if_ack = d_ack = 0`.
  - `if_rdata = d_rdata = 0`.
  - `last_grant = 1`, so fetch wins the first contention.
- `mem_we` is forced to 0 combinationally while `rst` is high. A write in flight when reset asserts is dropped and never acked; the requester must re-issue it.

## Timing
- Latency: request eligible and granted in cycle N → ack and rdata in cycle N+1.
- Lost contention in N → granted N+1, acked N+2. Maximum wait is one cycle, because the winner is ineligible during its ack cycle.
- Throughput:
  - One access per cycle with both requesters active (alternating).
  - One access per two cycles for a single requester.
- Write commits to `ram` at the edge ending the grant cycle. A subsequent granted read of the same word (earliest the next cycle) returns the new data.
- Requester may change address/data and keep `req` high in the cycle after ack; that starts a new request.
- `req` dropped before ack: protocol violation; behaviour undefined, no assertion required.

## Test plan
- Reset: hold `rst` 2 cycles with both requests high → `if_ack = d_ack = mem_we = 0`, `if_rdata = d_rdata = 0`. First contention after release grants fetch.
- Single fetch: `if_req = 1`, `if_addr = 0x010`, memory word 4 = 0xDEADBEEF → `mem_raddr = 0x010` in N, `if_ack = 1`, `if_rdata = 0xDEADBEEF` in N+1. Held `if_req` re-granted in N+2.
- Contention: both requests raised in the same cycle after reset → fetch granted N, data N+1, fetch N+2, and so on. Acks alternate every cycle, with no cycle where both acks are high.
- Write then read: data write 0x12345678 to 0x020, then data read 0x020 → `mem_we = 1` only in the write grant cycle, `d_ack` pulses twice, `d_rdata = 0x12345678`. A fetch of 0x020 then returns the same value.
- UART pass-through: data write to the UART address with `d_wdata = 0x00004101` → `mem_waddr` equals that address and `mem_we = 1` for exactly one cycle. A later data read of that address returns a value with bits [15:8] = 0x41.
- Reset mid-access: assert `rst` in a data write grant cycle → `mem_we = 0` in that cycle, no `d_ack` follows, and memory contents are unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Desc     : Two-port round-robin arbiter sharing a single-ported RAM
//             between the instruction-fetch port and the load/store port.
//             Grant is combinational; read data and acks are registered.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int WIDTH         = 32
) (
    input  logic                     clk,
    input  logic                     rst,

    // Instruction-fetch port
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic                     if_ack,
    output logic [WIDTH-1:0]         if_rdata,

    // Load/store port
    input  logic                     d_req,
    input  logic                     d_we,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0]         d_wdata,
    output logic                     d_ack,
    output logic [WIDTH-1:0]         d_rdata,

    // RAM side
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_raddr,
    output logic [ADDRESS_WIDTH-1:0] mem_waddr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata
);

    // Requester identifiers stored in the last-grant register
    localparam logic c_GRANT_IF = 1'b0;
    localparam logic c_GRANT_D  = 1'b1;

    logic             r_if_ack;
    logic             r_d_ack;
    logic [WIDTH-1:0] r_if_rdata;
    logic [WIDTH-1:0] r_d_rdata;
    logic             r_last_grant;

    logic             w_if_elig;
    logic             w_d_elig;
    logic             w_grant_if;
    logic             w_grant_d;

    // A requester sitting in its ack cycle is retiring its request, so it is
    // not eligible; this is also what bounds the loser's wait to one cycle.
    always_comb begin
        w_if_elig  = if_req & ~r_if_ack;
        w_d_elig   = d_req  & ~r_d_ack;
        w_grant_if = w_if_elig & (~w_d_elig | (r_last_grant == c_GRANT_D));
        w_grant_d  = w_d_elig  & (~w_if_elig | (r_last_grant == c_GRANT_IF));
    end

    // Memory-side steering; write path always carries the data port values
    always_comb begin
        mem_raddr = w_grant_d ? d_addr : if_addr;
        mem_waddr = d_addr;
        mem_wdata = d_wdata;
        mem_we    = w_grant_d & d_we & ~rst;
    end

    // Ack pulses, read-data capture and round-robin history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
            r_last_grant <= c_GRANT_D;
        end else begin
            r_if_ack <= w_grant_if;
            r_d_ack  <= w_grant_d;
            if (w_grant_if) begin
                r_last_grant <= c_GRANT_IF;
                r_if_rdata   <= mem_rdata;
            end
            if (w_grant_d) begin
                r_last_grant <= c_GRANT_D;
                if (!d_we) begin
                    r_d_rdata <= mem_rdata;
                end
            end
        end
    end

    assign if_ack   = r_if_ack;
    assign d_ack    = r_d_ack;
    assign if_rdata = r_if_rdata;
    assign d_rdata  = r_d_rdata;

endmodule
`default_nettype wire
